// File: rtl/spi_shift_engine_pkg.sv
// Shared definitions for the SPI shift engine: FSM encoding, default widths
// and the character-length decode helper.
package spi_shift_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 5;

    // A char_len of zero stands for a full-width character.
    function automatic int unsigned char_bits(input int unsigned char_len,
                                              input int unsigned data_w);
        return (char_len == 0) ? data_w : char_len;
    endfunction

endpackage

// File: rtl/spi_shift_engine_shift_reg.sv
// Transmit/receive shift registers with direction select and a right-justified
// read port that already includes a sample arriving in the current cycle.
module spi_shift_engine_shift_reg
    import spi_shift_engine_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic [LEN_W:0]    len_i,
    input  logic              lsb_first_i,
    input  logic              shift_i,
    input  logic              sample_i,
    input  logic              sample_bit_i,
    output logic              tap_o,
    output logic              next_tap_o,
    output logic [DATA_W-1:0] rd_word_o
);

    localparam logic [LEN_W:0] FULL = (LEN_W+1)'(DATA_W);

    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] rx_cur;
    logic              lsb_q;
    logic [LEN_W:0]    len_q;

    // MSB-first words are pre-shifted so bit len-1 sits at the top tap.
    always_ff @(posedge clk) begin
        if (load_i) begin
            tx_q  <= lsb_first_i ? load_data_i : (load_data_i << (FULL - len_i));
            rx_q  <= '0;
            lsb_q <= lsb_first_i;
            len_q <= len_i;
        end else begin
            if (shift_i) begin
                tx_q <= lsb_q ? (tx_q >> 1) : (tx_q << 1);
            end
            if (sample_i) begin
                rx_q <= rx_next;
            end
        end
    end

    always_comb begin
        rx_next    = lsb_q ? {sample_bit_i, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], sample_bit_i};
        rx_cur     = sample_i ? rx_next : rx_q;
        rd_word_o  = lsb_q ? (rx_cur >> (FULL - len_q)) : rx_cur;
        tap_o      = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
        next_tap_o = lsb_q ? tx_q[1] : tx_q[DATA_W-2];
    end

endmodule

// File: rtl/spi_shift_engine.sv
// Character-level SPI master transfer controller (IDLE/LOAD/SHIFT/DONE).
// Define SPI_LOOPBACK_EN to add the internal mosi->sample loopback port.
module spi_shift_engine
    import spi_shift_engine_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [LEN_W-1:0]  char_len,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              pos_edge,
    input  logic              neg_edge,
    input  logic              miso,
`ifdef SPI_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic              go,
    output logic              last_clk,
    output logic              mosi,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int EW = LEN_W + 2;

    state_t            state_q, state_d;
    logic [LEN_W:0]    len_q, len_d, len_in;
    logic              cpol_q, cpol_d, cpha_q, cpha_d;
    logic [EW-1:0]     edge_cnt_q, edge_cnt_d;
    logic [LEN_W:0]    bit_cnt_q, bit_cnt_d;
    logic              mosi_q, mosi_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;

    logic              accept, in_shift, pos_eff, neg_eff, lead, trail;
    logic              strobe, final_edge, sample, shift, sample_bit;
    logic              tap, next_tap;
    logic [DATA_W-1:0] rd_word;

    assign len_in = (LEN_W+1)'(char_bits(32'(char_len), DATA_W));

    // Coincident strobes collapse to a single rising edge.
    always_comb begin
        accept     = (state_q == ST_IDLE) && start && enable;
        in_shift   = (state_q == ST_SHIFT);
        pos_eff    = pos_edge;
        neg_eff    = neg_edge && !pos_edge;
        lead       = in_shift && (cpol_q ? neg_eff : pos_eff);
        trail      = in_shift && (cpol_q ? pos_eff : neg_eff);
        strobe     = lead || trail;
        final_edge = strobe && (edge_cnt_q == EW'(1));
        sample     = cpha_q ? trail : lead;
        shift      = trail;
    end

`ifdef SPI_LOOPBACK_EN
    assign sample_bit = loopback ? mosi_q : miso;
`else
    assign sample_bit = miso;
`endif

    spi_shift_engine_shift_reg #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_shift_reg (
        .clk          (sysclk),
        .load_i       (accept),
        .load_data_i  (tx_data),
        .len_i        (len_in),
        .lsb_first_i  (lsb_first),
        .shift_i      (shift),
        .sample_i     (sample),
        .sample_bit_i (sample_bit),
        .tap_o        (tap),
        .next_tap_o   (next_tap),
        .rd_word_o    (rd_word)
    );

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (final_edge) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (!enable) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        go       = (state_q == ST_SHIFT);
        last_clk = (state_q == ST_SHIFT) && (bit_cnt_q <= (LEN_W+1)'(1));
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
        mosi     = mosi_q;
        rx_data  = rx_data_q;
    end

    // The final trailing edge of cpha=0 sends nothing, so mosi keeps the last bit.
    always_comb begin
        len_d      = len_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        mosi_d     = mosi_q;
        rx_data_d  = rx_data_q;
        if (accept) begin
            len_d  = len_in;
            cpol_d = cpol;
            cpha_d = cpha;
        end
        if (state_q == ST_LOAD) begin
            edge_cnt_d = {len_q, 1'b0};
            bit_cnt_d  = len_q;
            if (!cpha_q) begin
                mosi_d = tap;
            end
        end
        if (strobe) begin
            edge_cnt_d = edge_cnt_q - EW'(1);
        end
        if (sample) begin
            bit_cnt_d = bit_cnt_q - (LEN_W+1)'(1);
        end
        if (cpha_q && lead) begin
            mosi_d = tap;
        end else if (!cpha_q && trail && !final_edge) begin
            mosi_d = next_tap;
        end
        if (final_edge && enable) begin
            rx_data_d = rd_word;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            len_q      <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            mosi_q     <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            len_q      <= len_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            mosi_q     <= mosi_d;
            rx_data_q  <= rx_data_d;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst_n && in_shift) begin
            assert (!(pos_edge && neg_edge));
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine with a transfer-level expectation model.
module tb_spi_shift_engine;

    logic        sysclk = 1'b0;
    logic        rst_n, enable, cpol, cpha, lsb_first, start, pos_edge, neg_edge;
    logic [4:0]  char_len;
    logic [31:0] tx_data;
    logic [1:0]  miso_mode;
    wire         miso;
    logic        go, last_clk, mosi, busy, done;
    logic [31:0] rx_data;

    int          checks = 0;
    int          errors = 0;
    logic        chk_en = 1'b0;
    logic        exp_busy = 1'b0, exp_go = 1'b0, exp_done = 1'b0;
    logic [31:0] exp_rx = '0;
    int          m_len = 1;
    int          samples_done = 0;
    logic        chk_mosi = 1'b0, exp_mosi = 1'b0;
    logic [31:0] cap;

    assign miso = (miso_mode == 2'd2) ? mosi : miso_mode[0];

    always #5 sysclk = ~sysclk;

    spi_shift_engine dut (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .enable    (enable),
        .cpol      (cpol),
        .cpha      (cpha),
        .lsb_first (lsb_first),
        .char_len  (char_len),
        .start     (start),
        .tx_data   (tx_data),
        .pos_edge  (pos_edge),
        .neg_edge  (neg_edge),
        .miso      (miso),
        .go        (go),
        .last_clk  (last_clk),
        .mosi      (mosi),
        .busy      (busy),
        .done      (done),
        .rx_data   (rx_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge sysclk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("go", 32'(go), 32'(exp_go));
            check("done", 32'(done), 32'(exp_done));
            check("rx_data", rx_data, exp_rx);
            check("last_clk", 32'(last_clk), 32'(exp_go && (samples_done >= m_len - 1)));
            if (chk_mosi) check("mosi_bit", 32'(mosi), 32'(exp_mosi));
        end
    end

    // abort_kind: 1 drops enable, 2 pulses reset, in the gap before edge abort_k.
    task automatic xfer(input logic [31:0] tx, input logic [4:0] clen, input logic lsb,
                        input logic pol, input logic pha, input logic [1:0] mm,
                        input int abort_k, input int abort_kind, input int restart_k);
        int          len;
        logic [31:0] rxe;
        logic        r;
        bit          lead, is_samp;
        len = (clen == 0) ? 32 : int'(clen);
        rxe = '0;
        for (int i = 0; i < len; i++) begin
            r = (mm == 2'd2) ? (lsb ? tx[i] : tx[len-1-i]) : mm[0];
            if (lsb) rxe[i] = r;
            else     rxe[len-1-i] = r;
        end
        cap = '0;
        @(posedge sysclk); #1;
        m_len = len; samples_done = 0;
        miso_mode = mm; cpol = pol; cpha = pha; lsb_first = lsb;
        char_len = clen; tx_data = tx; start = 1'b1;
        @(posedge sysclk); #1;
        start = 1'b0; tx_data = '0; exp_busy = 1'b1;
        @(posedge sysclk); #1;
        exp_go = 1'b1;
        for (int k = 0; k < 2 * len; k++) begin
            if (k == abort_k) begin
                if (abort_kind == 1) enable = 1'b0;
                else                 rst_n = 1'b0;
                @(posedge sysclk); #1;
                exp_busy = 1'b0; exp_go = 1'b0; exp_done = 1'b0;
                if (abort_kind == 2) exp_rx = '0;
                enable = 1'b1; rst_n = 1'b1;
                return;
            end
            @(posedge sysclk); #1;
            lead     = (k % 2 == 0);
            is_samp  = pha ? !lead : lead;
            pos_edge = (lead != pol);
            neg_edge = !(lead != pol);
            if (is_samp) begin
                chk_mosi = 1'b1;
                exp_mosi = lsb ? tx[k/2] : tx[len-1-k/2];
                cap = {cap[30:0], mosi};
            end
            if (k == restart_k) begin
                start = 1'b1; tx_data = '0;
            end
            @(posedge sysclk); #1;
            pos_edge = 1'b0; neg_edge = 1'b0; chk_mosi = 1'b0; start = 1'b0;
            if (is_samp) samples_done++;
            if (k == 2 * len - 1) begin
                exp_go = 1'b0; exp_done = 1'b1; exp_rx = rxe;
            end
        end
        @(posedge sysclk); #1;
        exp_busy = 1'b0; exp_done = 1'b0;
        @(posedge sysclk); #1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        char_len = 5'd8; start = 1'b0; tx_data = '0; pos_edge = 1'b0; neg_edge = 1'b0;
        miso_mode = 2'd0;
        repeat (3) @(posedge sysclk);
        #1;
        check("rst_go", 32'(go), 32'd0);
        check("rst_last_clk", 32'(last_clk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rx_data", rx_data, 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        xfer(32'h000000A5, 5'd8, 1'b0, 1'b0, 1'b0, 2'd2, -1, 0, -1);
        check("t1_rx", rx_data, 32'h000000A5);
        check("t1_mosi_seq", cap, 32'h000000A5);

        xfer(32'h0000000C, 5'd4, 1'b1, 1'b1, 1'b1, 2'd1, -1, 0, -1);
        check("t2_rx", rx_data, 32'h0000000F);
        check("t2_mosi_seq", cap, 32'h00000003);

        xfer(32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 2'd2, -1, 0, -1);
        check("t3_rx", rx_data, 32'hDEADBEEF);
        check("t3_mosi_seq", cap, 32'hDEADBEEF);

        xfer(32'h0000005A, 5'd8, 1'b0, 1'b0, 1'b0, 2'd2, 5, 1, -1);
        check("t4_rx_kept", rx_data, 32'hDEADBEEF);
        check("t4_go", 32'(go), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge sysclk);
        #1;

        xfer(32'h0000003C, 5'd8, 1'b1, 1'b1, 1'b0, 2'd2, -1, 0, 4);
        check("t5_rx", rx_data, 32'h0000003C);

        xfer(32'h00000001, 5'd1, 1'b0, 1'b0, 1'b0, 2'd0, -1, 0, -1);
        check("t6_rx", rx_data, 32'h00000000);
        check("t6_mosi", 32'(mosi), 32'd1);

        xfer(32'h000000FF, 5'd8, 1'b0, 1'b0, 1'b0, 2'd2, 3, 2, -1);
        check("t7_rx", rx_data, 32'h00000000);
        check("t7_mosi", 32'(mosi), 32'd0);
        check("t7_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge sysclk);
        #1;

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
